// File: rtl/wb_watchdog_pkg.sv
// Shared definitions for the Wishbone bus watchdog.
//   - FSM state encoding (idle / forwarding / responding)
//   - default error read data and local status register address
//   - error counter width and its saturating increment helper
package wb_watchdog_pkg;

  typedef logic [1:0] wdt_state_t;

  localparam wdt_state_t StIdle = 2'd0;
  localparam wdt_state_t StFwd  = 2'd1;
  localparam wdt_state_t StResp = 2'd2;

  localparam logic [31:0] WdtErrData   = 32'hDEAD_BEEF;
  localparam logic [31:0] WdtStatusAdr = 32'h3000_FFFC;

  localparam int unsigned ErrCntW = 16;

  // Holds at all-ones instead of wrapping.
  function automatic logic [ErrCntW-1:0] sat_inc(input logic [ErrCntW-1:0] v);
    return (v == '1) ? v : v + ErrCntW'(1);
  endfunction

endpackage

// File: rtl/wb_wdt_counter.sv
// Watchdog cycle counter: an up-counter that loads zero on clear_i, counts while en_i
// is high, and flags the last allowed cycle of a forwarded request.
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   clear_i load zero (takes priority over en_i)
//   en_i    count enable
//   tc_o    high while the count equals TIMEOUT_CYCLES-1
module wb_wdt_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] TcVal = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TcVal);

endmodule

// File: rtl/wb_bus_watchdog.sv
// Wishbone pass-through stage with a response watchdog. Each upstream request is
// registered and forwarded downstream; if the downstream ack does not arrive within
// TIMEOUT_CYCLES strobe cycles, the cycle is terminated locally with ERR_DATA.
//
// Optional feature macro: WB_WATCHDOG_STATUS_EN -- serves STATUS_ADR locally
// (read: {15'b0, last_was_timeout, err_count}; write: clears both).
//
// Ports:
//   wb_clk_i, wb_nrst_i             clock, asynchronous active-low reset
//   wbs_cyc/stb/we/sel/adr/dat_i    upstream request
//   wbs_ack_o, wbs_dat_o            upstream response (registered, one-cycle ack)
//   s_cyc/stb/we/sel/adr/dat_o      downstream request (registered)
//   s_ack_i, s_dat_i                downstream response
//   timeout_o                       one-cycle pulse per timeout
//   err_count_o                     saturating timeout count
module wb_bus_watchdog
  import wb_watchdog_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = WdtErrData,
  parameter logic [31:0] STATUS_ADR     = WdtStatusAdr
) (
  input  logic               wb_clk_i,
  input  logic               wb_nrst_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic               s_stb_o,
  output logic               s_cyc_o,
  output logic               s_we_o,
  output logic [3:0]         s_sel_o,
  output logic [31:0]        s_adr_o,
  output logic [31:0]        s_dat_o,
  input  logic               s_ack_i,
  input  logic [31:0]        s_dat_i,
  output logic               timeout_o,
  output logic [ErrCntW-1:0] err_count_o
);

  wdt_state_t         state_q, state_d;
  logic               strb_q, strb_d;
  logic               we_q, we_d;
  logic [3:0]         sel_q, sel_d;
  logic [31:0]        adr_q, adr_d;
  logic [31:0]        wdat_q, wdat_d;
  logic [31:0]        rdat_q, rdat_d;
  logic               ack_q, ack_d;
  logic               tmo_q, tmo_d;
  logic [ErrCntW-1:0] err_cnt_q, err_cnt_d;
  logic               cnt_clear, cnt_en, cnt_tc;
  logic               status_hit;

`ifdef WB_WATCHDOG_STATUS_EN
  logic last_tmo_q, last_tmo_d;
  assign status_hit = (wbs_adr_i == STATUS_ADR);
`else
  assign status_hit = 1'b0;
`endif

  wb_wdt_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_counter (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_nrst_i),
    .clear_i(cnt_clear),
    .en_i   (cnt_en),
    .tc_o   (cnt_tc)
  );

  always_comb begin
    state_d   = state_q;
    strb_d    = strb_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    rdat_d    = rdat_q;
    ack_d     = 1'b0;
    tmo_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
`ifdef WB_WATCHDOG_STATUS_EN
    last_tmo_d = last_tmo_q;
`endif
    case (state_q)
      StIdle: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          if (status_hit) begin
`ifdef WB_WATCHDOG_STATUS_EN
            // Local register: answered straight from IDLE, never forwarded.
            state_d = StResp;
            ack_d   = 1'b1;
            rdat_d  = {15'b0, last_tmo_q, err_cnt_q};
            if (wbs_we_i) begin
              err_cnt_d  = '0;
              last_tmo_d = 1'b0;
            end
`endif
          end else begin
            state_d   = StFwd;
            strb_d    = 1'b1;
            we_d      = wbs_we_i;
            sel_d     = wbs_sel_i;
            adr_d     = wbs_adr_i;
            wdat_d    = wbs_dat_i;
            cnt_clear = 1'b1;
          end
        end
      end
      StFwd: begin
        cnt_en = 1'b1;
        // Abort beats ack beats timeout.
        if (!wbs_cyc_i) begin
          state_d = StIdle;
          strb_d  = 1'b0;
        end else if (s_ack_i) begin
          state_d = StResp;
          strb_d  = 1'b0;
          rdat_d  = s_dat_i;
          ack_d   = 1'b1;
`ifdef WB_WATCHDOG_STATUS_EN
          last_tmo_d = 1'b0;
`endif
        end else if (cnt_tc) begin
          state_d   = StResp;
          strb_d    = 1'b0;
          rdat_d    = ERR_DATA;
          ack_d     = 1'b1;
          tmo_d     = 1'b1;
          err_cnt_d = sat_inc(err_cnt_q);
`ifdef WB_WATCHDOG_STATUS_EN
          last_tmo_d = 1'b1;
`endif
        end
      end
      StResp: begin
        // Ack is already on the outputs; never re-accept in this cycle.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        strb_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_nrst_i) begin
    if (!wb_nrst_i) begin
      state_q   <= StIdle;
      strb_q    <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      wdat_q    <= '0;
      rdat_q    <= '0;
      ack_q     <= 1'b0;
      tmo_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      strb_q    <= strb_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      wdat_q    <= wdat_d;
      rdat_q    <= rdat_d;
      ack_q     <= ack_d;
      tmo_q     <= tmo_d;
      err_cnt_q <= err_cnt_d;
    end
  end

`ifdef WB_WATCHDOG_STATUS_EN
  always_ff @(posedge wb_clk_i or negedge wb_nrst_i) begin
    if (!wb_nrst_i) begin
      last_tmo_q <= 1'b0;
    end else begin
      last_tmo_q <= last_tmo_d;
    end
  end
`endif

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = rdat_q;
  assign s_stb_o     = strb_q;
  assign s_cyc_o     = strb_q;
  assign s_we_o      = we_q;
  assign s_sel_o     = sel_q;
  assign s_adr_o     = adr_q;
  assign s_dat_o     = wdat_q;
  assign timeout_o   = tmo_q;
  assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_wb_bus_watchdog.sv
module tb_wb_bus_watchdog;

  localparam int unsigned To        = 8;
  localparam logic [31:0] ErrData   = 32'hDEAD_BEEF;
  localparam logic [31:0] StatusAdr = 32'h3000_FFFC;

  logic        clk = 1'b0;
  logic        nrst;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        s_stb_o, s_cyc_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic        s_ack_i;
  logic [31:0] s_dat_i;
  logic        timeout_o;
  logic [15:0] err_count_o;

  always #5 clk = ~clk;

  wb_bus_watchdog #(
    .TIMEOUT_CYCLES(To),
    .ERR_DATA      (ErrData),
    .STATUS_ADR    (StatusAdr)
  ) dut (
    .wb_clk_i   (clk),
    .wb_nrst_i  (nrst),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .s_stb_o    (s_stb_o),
    .s_cyc_o    (s_cyc_o),
    .s_we_o     (s_we_o),
    .s_sel_o    (s_sel_o),
    .s_adr_o    (s_adr_o),
    .s_dat_o    (s_dat_o),
    .s_ack_i    (s_ack_i),
    .s_dat_i    (s_dat_i),
    .timeout_o  (timeout_o),
    .err_count_o(err_count_o)
  );

  // Expected outputs for one cycle; rel is the cycle index within a transaction.
  typedef struct {
    int unsigned rel;
    logic        ack;
    logic [31:0] dat;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] sdat;
    logic        tmo;
    logic [15:0] cnt;
  } exp_t;

  // Literal pins: 0 ack cycle, 1 ack data, 2 strobe cycles, 3 timeouts, else err_count_o.
  typedef struct {
    string       name;
    int unsigned what;
    logic [31:0] val;
  } lit_t;

  exp_t exp_q[$];
  lit_t lit_q[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Transaction-level model state: what the block's visible registers must hold.
  logic [31:0] m_dat, m_adr, m_sdat;
  logic        m_we, m_last;
  logic [3:0]  m_sel;
  logic [15:0] m_cnt;

  task automatic model_reset();
    m_dat = '0; m_adr = '0; m_sdat = '0; m_we = 1'b0; m_sel = '0; m_cnt = '0; m_last = 1'b0;
  endtask

  task automatic push_exp(input int unsigned rel, input logic ack, input logic stb,
                          input logic tmo);
    exp_t e;
    e.rel = rel; e.ack = ack; e.dat = m_dat; e.stb = stb; e.we = m_we; e.sel = m_sel;
    e.adr = m_adr; e.sdat = m_sdat; e.tmo = tmo; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic pin(input string nm, input int unsigned what, input logic [31:0] val);
    lit_t l;
    l.name = nm; l.what = what; l.val = val;
    lit_q.push_back(l);
  endtask

  task automatic drive(input logic cyc, input logic stb, input logic we, input logic [3:0] sel,
                       input logic [31:0] adr, input logic [31:0] wdat, input logic sack,
                       input logic [31:0] sdat);
    wbs_cyc_i = cyc; wbs_stb_i = stb; wbs_we_i = we; wbs_sel_i = sel;
    wbs_adr_i = adr; wbs_dat_i = wdat; s_ack_i = sack; s_dat_i = sdat;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'($urandom_range(0, 1)), $urandom());
      push_exp(999, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // One upstream request. d: cycle of the downstream ack (0 = none).
  // a: cycle upstream drops cyc (0 = never). late: stray s_ack_i after an abort.
  task automatic run_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] wdat, input logic [31:0] rdat,
                         input int unsigned d, input int unsigned a, input logic late);
    int unsigned e;
    int          kind;  // 0 ack, 1 timeout, 2 abort
    e = To; kind = 1;
    if (d >= 1 && d <= e) begin e = d; kind = 0; end
    if (a >= 1 && a <= e) begin e = a; kind = 2; end
    for (int unsigned rel = 0; rel < e + 2; rel++) begin
      logic up, sack, fin;
      @(posedge clk); #1;
      up   = (kind == 2) ? (rel < a) : (rel <= e + 1);
      sack = (d != 0 && rel == d) || (kind == 2 && late && rel == e + 1);
      drive(up, up, we, sel, adr, wdat, sack, (d != 0 && rel == d) ? rdat : $urandom());
      if (rel == 1) begin m_we = we; m_sel = sel; m_adr = adr; m_sdat = wdat; end
      fin = (rel == e + 1) && (kind != 2);
      if (fin) begin
        m_dat = (kind == 0) ? rdat : ErrData;
        if (kind == 1) begin
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          m_last = 1'b1;
        end else begin
          m_last = 1'b0;
        end
      end
      push_exp(rel, fin, (rel >= 1 && rel <= e), fin && kind == 1);
    end
  endtask

  task automatic run_status(input logic we, input logic [31:0] wdat);
    for (int unsigned rel = 0; rel < 3; rel++) begin
      logic up;
      @(posedge clk); #1;
      up = (rel <= 1);
      drive(up, up, we, 4'hF, StatusAdr, wdat, 1'b0, $urandom());
      if (rel == 1) begin
        m_dat = {15'b0, m_last, m_cnt};
        if (we) begin m_cnt = '0; m_last = 1'b0; end
      end
      push_exp(rel, rel == 1, 1'b0, 1'b0);
    end
  endtask

  task automatic chk(input string nm, input int unsigned rel, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s rel=%0d t=%0t actual=%h required=%h", nm, rel, $time, act, req);
    end
  endtask

  // Single compare process: per-cycle model check, then any pending literal pins.
  initial begin : compare
    exp_t        e;
    lit_t        l;
    logic [31:0] act;
    logic [31:0] obs_ack_rel, obs_ack_dat;
    int unsigned obs_stb, obs_tmo;
    obs_ack_rel = '1; obs_ack_dat = '0; obs_stb = 0; obs_tmo = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.rel == 0) begin
          obs_ack_rel = '1; obs_ack_dat = '0; obs_stb = 0; obs_tmo = 0;
        end
        if (wbs_ack_o === 1'b1) begin obs_ack_rel = e.rel; obs_ack_dat = wbs_dat_o; end
        if (s_stb_o === 1'b1) obs_stb++;
        if (timeout_o === 1'b1) obs_tmo++;
        chk("wbs_ack_o", e.rel, 32'(wbs_ack_o), 32'(e.ack));
        chk("wbs_dat_o", e.rel, wbs_dat_o, e.dat);
        chk("s_stb_o", e.rel, 32'(s_stb_o), 32'(e.stb));
        chk("s_cyc_o", e.rel, 32'(s_cyc_o), 32'(e.stb));
        chk("s_we_o", e.rel, 32'(s_we_o), 32'(e.we));
        chk("s_sel_o", e.rel, 32'(s_sel_o), 32'(e.sel));
        chk("s_adr_o", e.rel, s_adr_o, e.adr);
        chk("s_dat_o", e.rel, s_dat_o, e.sdat);
        chk("timeout_o", e.rel, 32'(timeout_o), 32'(e.tmo));
        chk("err_count_o", e.rel, 32'(err_count_o), 32'(e.cnt));
      end
      while (lit_q.size() != 0) begin
        l = lit_q.pop_front();
        case (l.what)
          0:       act = obs_ack_rel;
          1:       act = obs_ack_dat;
          2:       act = obs_stb;
          3:       act = obs_tmo;
          default: act = 32'(err_count_o);
        endcase
        chk(l.name, 0, act, l.val);
      end
    end
  end

  initial begin : stim
    logic [31:0] adr;
    nrst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    model_reset();
    #2 nrst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      push_exp(999, 1'b0, 1'b0, 1'b0);
    end
    #2 nrst = 1'b1;
    pin("reset_err_count", 4, 32'h0);
    idle(1);

    // Ack 3 cycles after s_stb_o rises.
    run_txn(1'b0, 4'hF, 32'h3000_0010, 32'h0, 32'h1234_5678, 4, 0, 1'b0);
    pin("rd_ack_cycle", 0, 32'd5);
    pin("rd_ack_data", 1, 32'h1234_5678);
    pin("rd_no_timeout", 3, 32'd0);
    pin("rd_stb_cycles", 2, 32'd4);
    idle(1);

    // No downstream ack: timeout.
    run_txn(1'b0, 4'h3, 32'h3000_0020, 32'h0, 32'h0, 0, 0, 1'b0);
    pin("tmo_ack_cycle", 0, To + 1);
    pin("tmo_ack_data", 1, 32'hDEAD_BEEF);
    pin("tmo_stb_cycles", 2, To);
    pin("tmo_pulses", 3, 32'd1);
    pin("tmo_err_count", 4, 32'd1);

    // Ack on the last allowed cycle wins over timeout.
    run_txn(1'b0, 4'hF, 32'h3000_0030, 32'h0, 32'hCAFE_0008, To, 0, 1'b0);
    pin("edge_ack_cycle", 0, To + 1);
    pin("edge_ack_data", 1, 32'hCAFE_0008);
    pin("edge_no_timeout", 3, 32'd0);
    pin("edge_err_count", 4, 32'd1);

    // Upstream abort in FWD cycle 3 with a stray late ack, then a normal write.
    run_txn(1'b1, 4'h1, 32'h3000_0040, 32'h5555_AAAA, 32'h0, 0, 3, 1'b1);
    pin("abort_no_ack", 0, 32'hFFFF_FFFF);
    pin("abort_stb_cycles", 2, 32'd3);
    run_txn(1'b1, 4'hC, 32'h3000_0044, 32'h0BAD_F00D, 32'h7777_0001, 2, 0, 1'b0);
    pin("post_abort_ack_cycle", 0, 32'd3);
    pin("post_abort_ack_data", 1, 32'h7777_0001);

    // Asynchronous reset in the middle of FWD.
    for (int unsigned rel = 0; rel < 5; rel++) begin
      @(posedge clk); #1;
      if (rel < 4) drive(1'b1, 1'b1, 1'b1, 4'hF, 32'h3000_0050, 32'h1111_2222, 1'b0, $urandom());
      else drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, $urandom());
      if (rel == 1) begin m_we = 1'b1; m_sel = 4'hF; m_adr = 32'h3000_0050; m_sdat = 32'h1111_2222; end
      if (rel >= 3) model_reset();
      push_exp(rel, 1'b0, (rel == 1 || rel == 2), 1'b0);
      if (rel == 3) #2 nrst = 1'b0;
      if (rel == 4) #2 nrst = 1'b1;
    end
    pin("reset_mid_err_count", 4, 32'd0);
    idle(1);
    run_txn(1'b0, 4'hF, 32'h3000_0060, 32'h0, 32'hABCD_0123, 1, 0, 1'b0);
    pin("post_reset_ack_cycle", 0, 32'd2);
    pin("post_reset_ack_data", 1, 32'hABCD_0123);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      int unsigned d, a;
      adr = $urandom();
      if (adr == StatusAdr) adr = adr ^ 32'h1;
      d = $urandom_range(0, 12);
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 0;
      run_txn(1'($urandom_range(0, 1)), 4'($urandom()), adr, $urandom(), $urandom(), d, a,
              1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end

`ifdef WB_WATCHDOG_STATUS_EN
    run_status(1'b1, 32'h0);
    for (int i = 0; i < 3; i++) run_txn(1'b0, 4'hF, 32'h3000_0070, 32'h0, 32'h0, 0, 0, 1'b0);
    run_status(1'b0, 32'h0);
    pin("status_rd_cycle", 0, 32'd1);
    pin("status_rd_data", 1, 32'h0001_0003);
    pin("status_no_stb", 2, 32'd0);
    run_status(1'b1, 32'h1234_5678);
    run_status(1'b0, 32'h0);
    pin("status_cleared", 1, 32'h0);
`endif

    idle(2);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
